// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//
// SPI mode-0 target that answers the 0x03 READ command and streams bytes
// from a synchronous-read memory port. It is an SPI RAM/flash emulator for
// on-chip loopback and FPGA prototypes. All SPI pins are oversampled in the
// clk domain; spi_clk is never used as a clock.
//
// Ports
//   clk, rst          system clock, async active-high reset
//   spi_clk           host SCK (idles low), sampled
//   spi_select        host chip select, active-low, sampled
//   spi_mosi          host-to-target data, sampled
//   spi_miso          target-to-host data, registered, 0 outside DATA
//   spi_miso_oe       high only in DATA
//   rd_en / rd_addr   one-cycle memory read strobe and its address
//   rd_data           memory data, valid one cycle after rd_en
//   busy              synchronized select is low
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | select high, nothing in progress
// CMD    | shifting in the 8-bit command on SCK rises
// ADDR   | shifting in ADDR_BITS address bits on SCK rises
// DATA   | driving MISO on SCK falls, prefetching the next byte
// IGNORE | unsupported command, consume clocks until deselect

module spi_flash_responder #(
   parameter int ADDR_BITS   = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 spi_clk,
   input  logic                 spi_select,
   input  logic                 spi_mosi,
   output logic                 spi_miso,
   output logic                 spi_miso_oe,
   output logic                 rd_en,
   output logic [ADDR_BITS-1:0] rd_addr,
   input  logic [7:0]           rd_data,
   output logic                 busy
);

   localparam int SH_W  = (ADDR_BITS > 8) ? ADDR_BITS : 8;
   localparam int CNT_W = $clog2(SH_W);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_IGNORE
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] sel_sync_q, sel_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sck_hist_q, sck_hist_d;
   logic                   mosi_hist_q, mosi_hist_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [SH_W-1:0]        sh_in_q, sh_in_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic [7:0]             hold_q, hold_d;
   logic [7:0]             sh_out_q, sh_out_d;
   logic [2:0]             bit_q, bit_d;
   logic                   miso_q, miso_d;
   logic                   oe_q, oe_d;
   logic                   rd_en_q, rd_en_d;
   logic                   rd_pend_q, rd_pend_d;

   logic                   sck_now, sel_now;
   logic                   sck_rise, sck_fall;
   logic [SH_W-1:0]        sh_in_next;

   always_comb begin
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
      sel_sync_d  = {sel_sync_q[SYNC_STAGES-2:0], spi_select};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_now     = sck_sync_q[SYNC_STAGES-1];
      sel_now     = sel_sync_q[SYNC_STAGES-1];
      sck_hist_d  = sck_now;
      mosi_hist_d = mosi_sync_q[SYNC_STAGES-1];
      sck_rise    = sck_now & ~sck_hist_q;
      sck_fall    = ~sck_now & sck_hist_q;
      // MOSI history has the same age as the SCK history, i.e. the value
      // present just before the detected rise.
      sh_in_next  = {sh_in_q[SH_W-2:0], mosi_hist_q};

      state_d   = state_q;
      cnt_d     = cnt_q;
      sh_in_d   = sh_in_q;
      addr_d    = addr_q;
      hold_d    = hold_q;
      sh_out_d  = sh_out_q;
      bit_d     = bit_q;
      miso_d    = miso_q;
      rd_en_d   = 1'b0;
      rd_pend_d = rd_en_q;

      if (rd_pend_q) begin
         hold_d = rd_data;
      end

      if (sel_now) begin
         // Deselect wins over any edge seen in the same cycle.
         state_d = ST_IDLE;
         cnt_d   = '0;
         bit_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_CMD;
               cnt_d   = CNT_W'(7);
               sh_in_d = '0;
            end
            ST_CMD: begin
               if (sck_rise) begin
                  sh_in_d = sh_in_next;
                  if (cnt_q == '0) begin
                     if (sh_in_next[7:0] == 8'h03) begin
                        state_d = ST_ADDR;
                        cnt_d   = CNT_W'(ADDR_BITS - 1);
                     end else begin
                        state_d = ST_IGNORE;
                     end
                  end else begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end
            end
            ST_ADDR: begin
               if (sck_rise) begin
                  sh_in_d = sh_in_next;
                  if (cnt_q == '0) begin
                     addr_d  = sh_in_next[ADDR_BITS-1:0];
                     rd_en_d = 1'b1;
                     bit_d   = '0;
                     state_d = ST_DATA;
                  end else begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (sck_fall) begin
                  if (bit_q == 3'd0) begin
                     sh_out_d = hold_q;
                     miso_d   = hold_q[7];
                     bit_d    = 3'd7;
                  end else begin
                     sh_out_d = {sh_out_q[6:0], 1'b0};
                     miso_d   = sh_out_q[6];
                     bit_d    = bit_q - 3'd1;
                     // bit 0 goes out now: prefetch the next byte
                     if (bit_q == 3'd1) begin
                        addr_d  = addr_q + ADDR_BITS'(1);
                        rd_en_d = 1'b1;
                     end
                  end
               end
            end
            ST_IGNORE: begin
               state_d = ST_IGNORE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      oe_d = (state_d == ST_DATA);
      if (state_d != ST_DATA) begin
         miso_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sck_sync_q  <= '0;
         sel_sync_q  <= '1;
         mosi_sync_q <= '0;
         sck_hist_q  <= 1'b0;
         mosi_hist_q <= 1'b0;
         cnt_q       <= '0;
         sh_in_q     <= '0;
         addr_q      <= '0;
         hold_q      <= '0;
         sh_out_q    <= '0;
         bit_q       <= '0;
         miso_q      <= 1'b0;
         oe_q        <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_pend_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sck_sync_q  <= sck_sync_d;
         sel_sync_q  <= sel_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sck_hist_q  <= sck_hist_d;
         mosi_hist_q <= mosi_hist_d;
         cnt_q       <= cnt_d;
         sh_in_q     <= sh_in_d;
         addr_q      <= addr_d;
         hold_q      <= hold_d;
         sh_out_q    <= sh_out_d;
         bit_q       <= bit_d;
         miso_q      <= miso_d;
         oe_q        <= oe_d;
         rd_en_q     <= rd_en_d;
         rd_pend_q   <= rd_pend_d;
      end
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = oe_q;
   assign rd_en       = rd_en_q;
   assign rd_addr     = addr_q;
   assign busy        = ~sel_sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: a host model drives SPI transactions, a
// memory model answers rd_en, and two monitors check rd_addr and MISO bytes
// against queues filled when each transaction is issued.

module tb_spi_flash_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        spi_clk;
   logic        spi_select;
   logic        spi_mosi;
   logic        spi_miso;
   logic        spi_miso_oe;
   logic        rd_en;
   logic [15:0] rd_addr;
   logic [7:0]  rd_data;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic [15:0] exp_addr_q[$];
   logic [7:0]  exp_byte_q[$];
   logic        oe_seen = 1'b0;
   logic        rd_en_prev = 1'b0;
   int          nbit = 0;
   logic [7:0]  got = 8'h00;

   spi_flash_responder #(.ADDR_BITS(16), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .spi_clk     (spi_clk),
      .spi_select  (spi_select),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // memory contents: byte at address a is a[7:0] ^ 0xA5
   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      return a[7:0] ^ 8'hA5;
   endfunction

   always @(posedge clk) rd_data <= mem_byte(rd_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // rd_en monitor
   always @(negedge clk) begin
      if (spi_miso_oe) oe_seen = 1'b1;
      if (rd_en) begin
         if (rd_en_prev) begin
            total++;
            bad++;
            $display("FAIL rd_en_width: got 2+ cycles expected 1");
         end
         if (exp_addr_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_addr_unexpected: got %0h expected no rd_en", rd_addr);
         end else begin
            check("rd_addr", 32'(rd_addr), 32'(exp_addr_q.pop_front()));
         end
      end
      rd_en_prev = rd_en;
   end

   // MISO byte monitor: host samples on each SCK rise while MISO is driven
   always @(posedge spi_clk or posedge spi_select or posedge rst) begin
      if (rst || spi_select) begin
         nbit = 0;
      end else if (spi_miso_oe) begin
         got = {got[6:0], spi_miso};
         nbit++;
         if (nbit == 8) begin
            nbit = 0;
            if (exp_byte_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL miso_unexpected: got %0h expected no byte", got);
            end else begin
               check("miso_byte", 32'(got), 32'(exp_byte_q.pop_front()));
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic xbit(input logic b);
      spi_mosi = b;
      cyc(6);
      spi_clk = 1'b1;
      cyc(6);
      spi_clk = 1'b0;
   endtask

   task automatic xbyte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) xbit(v[i]);
   endtask

   task automatic header(input logic [15:0] a);
      spi_select = 1'b0;
      cyc(6);
      xbyte(8'h03);
      for (int i = 15; i >= 0; i--) xbit(a[i]);
   endtask

   // Every 8th SCK fall in DATA prefetches, so n bytes give n+1 reads.
   task automatic read_txn(input logic [15:0] a, input int nbytes, input int pause_at);
      for (int i = 0; i <= nbytes; i++) exp_addr_q.push_back(a + 16'(i));
      for (int i = 0; i < nbytes; i++) exp_byte_q.push_back(mem_byte(a + 16'(i)));
      header(a);
      for (int i = 0; i < 8 * nbytes; i++) begin
         if (i == pause_at) cyc(200);
         xbit(1'($urandom));
      end
      cyc(6);
      spi_select = 1'b1;
      cyc(8);
   endtask

   task automatic ignore_txn(input logic [7:0] cmd, input int nclk);
      spi_select = 1'b0;
      cyc(6);
      oe_seen = 1'b0;
      xbyte(cmd);
      for (int i = 0; i < nclk; i++) xbit(1'($urandom));
      check("busy_ignore", 32'(busy), 32'd1);
      cyc(6);
      check("oe_ignore", 32'(oe_seen), 32'd0);
      spi_select = 1'b1;
      cyc(8);
      check("busy_after_ignore", 32'(busy), 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      spi_clk    = 1'b0;
      spi_select = 1'b1;
      spi_mosi   = 1'b0;
      cyc(3);
      check("rst_miso",    32'(spi_miso),    32'd0);
      check("rst_oe",      32'(spi_miso_oe), 32'd0);
      check("rst_rd_en",   32'(rd_en),       32'd0);
      check("rst_rd_addr", 32'(rd_addr),     32'd0);
      check("rst_busy",    32'(busy),        32'd0);
      rst = 1'b0;
      cyc(5);

      read_txn(16'h1234, 1, -1);
      read_txn(16'h00FE, 4, -1);
      read_txn(16'hFFFF, 2, -1);
      ignore_txn(8'h9F, 24);
      read_txn(16'h0042, 1, -1);

      // deselect after 10 address bits
      spi_select = 1'b0;
      cyc(6);
      xbyte(8'h03);
      for (int i = 0; i < 10; i++) xbit(1'($urandom));
      cyc(6);
      spi_select = 1'b1;
      cyc(8);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_oe",   32'(spi_miso_oe), 32'd0);

      read_txn(16'h0001, 1, 3);

      // reset during the third data bit
      exp_addr_q.push_back(16'h1234);
      header(16'h1234);
      xbit(1'b0);
      xbit(1'b0);
      spi_mosi = 1'b0;
      cyc(3);
      rst = 1'b1;
      #1;
      check("midrst_miso",    32'(spi_miso),    32'd0);
      check("midrst_oe",      32'(spi_miso_oe), 32'd0);
      check("midrst_rd_en",   32'(rd_en),       32'd0);
      check("midrst_rd_addr", 32'(rd_addr),     32'd0);
      check("midrst_busy",    32'(busy),        32'd0);
      cyc(2);
      spi_select = 1'b1;
      cyc(4);
      rst = 1'b0;
      cyc(4);
      read_txn(16'h1234, 1, -1);

      for (int k = 0; k < 8; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            logic [7:0] c;
            c = 8'($urandom);
            if (c == 8'h03) c = 8'h0B;
            ignore_txn(c, $urandom_range(0, 20));
         end else begin
            int nb;
            nb = $urandom_range(1, 3);
            read_txn(16'($urandom), nb,
                     ($urandom_range(0, 1) == 1) ? $urandom_range(0, 8 * nb - 1) : -1);
         end
      end

      cyc(20);
      check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
      check("byte_queue_drained", 32'(exp_byte_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
